// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the address-decoded
// targets (main memory and GPIO). The arbiter connects through the slave modport.
interface bus_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        mem_we;
   logic        gpio_we;
   logic [31:0] mem_rdata;
   logic [31:0] gpio_rdata;
   logic [1:0]  gnt;

   modport slave (
      input  m0_req,
      input  m0_we,
      input  m0_addr,
      input  m0_wdata,
      output m0_ack,
      output m0_err,
      output m0_rdata,
      input  m1_req,
      input  m1_we,
      input  m1_addr,
      input  m1_wdata,
      output m1_ack,
      output m1_err,
      output m1_rdata,
      output bus_addr,
      output bus_wdata,
      output mem_we,
      output gpio_we,
      input  mem_rdata,
      input  gpio_rdata,
      output gnt
   );

   modport master (
      output m0_req,
      output m0_we,
      output m0_addr,
      output m0_wdata,
      input  m0_ack,
      input  m0_err,
      input  m0_rdata,
      output m1_req,
      output m1_we,
      output m1_addr,
      output m1_wdata,
      input  m1_ack,
      input  m1_err,
      input  m1_rdata,
      input  bus_addr,
      input  bus_wdata,
      input  mem_we,
      input  gpio_we,
      output mem_rdata,
      output gpio_rdata,
      input  gnt
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with a single outstanding transaction sharing
// the memory/GPIO data bus. Every transaction takes IDLE -> ACCESS -> RESP.
module bus_arbiter #(
   parameter logic [31:0] GPIO_BASE = 32'hF000_0000,
   parameter logic [31:0] GPIO_END  = 32'hF000_0006
) (
   input  logic         clk,
   input  logic         reset,
   bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      TGT_MEM,
      TGT_GPIO,
      TGT_NONE
   } target_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  gnt_q;
   logic [1:0]  gnt_nxt;
   logic        last_m1;
   logic        last_m1_nxt;
   logic [31:0] addr_q;
   logic [31:0] addr_nxt;
   logic [31:0] wdata_q;
   logic [31:0] wdata_nxt;
   logic        we_q;
   logic        we_nxt;

   logic        any_req;
   logic        pick_m1;
   target_t     target;
   logic        in_access;
   logic        in_resp;
   logic [31:0] resp_rdata;
   logic        resp_err;

   // On a tie the master that was not served last wins; a lone requester always wins.
   always_comb begin
      any_req = bus.m0_req | bus.m1_req;
      pick_m1 = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
         pick_m1 = ~last_m1;
      end else begin
         pick_m1 = bus.m1_req;
      end
   end

   always_comb begin
      target = TGT_NONE;
      if (addr_q < GPIO_BASE) begin
         target = TGT_MEM;
      end else if (addr_q < GPIO_END) begin
         target = TGT_GPIO;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt_q;
      last_m1_nxt = last_m1;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      we_nxt      = we_q;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = ACCESS;
               gnt_nxt   = pick_m1 ? 2'b10 : 2'b01;
               addr_nxt  = pick_m1 ? bus.m1_addr : bus.m0_addr;
               wdata_nxt = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
               we_nxt    = pick_m1 ? bus.m1_we : bus.m0_we;
            end
         end
         ACCESS: begin
            state_nxt = RESP;
         end
         RESP: begin
            state_nxt   = IDLE;
            gnt_nxt     = 2'b00;
            last_m1_nxt = gnt_q[1];
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
         end
      endcase
   end

   // The pointer resets to master 1 so master 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gnt_q   <= 2'b00;
         last_m1 <= 1'b1;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         we_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt_q   <= gnt_nxt;
         last_m1 <= last_m1_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         we_q    <= we_nxt;
      end
   end

   // Targets answer reads one cycle after seeing bus_addr, so read data is steered in RESP.
   always_comb begin
      in_access  = (state == ACCESS);
      in_resp    = (state == RESP);
      resp_err   = (target == TGT_NONE);
      resp_rdata = 32'h0;
      if (!we_q) begin
         case (target)
            TGT_MEM:  resp_rdata = bus.mem_rdata;
            TGT_GPIO: resp_rdata = bus.gpio_rdata;
            default:  resp_rdata = 32'h0;
         endcase
      end
   end

   always_comb begin
      bus.mem_we    = in_access & we_q & (target == TGT_MEM);
      bus.gpio_we   = in_access & we_q & (target == TGT_GPIO);
      bus.bus_addr  = addr_q;
      bus.bus_wdata = wdata_q;
      bus.gnt       = gnt_q;

      bus.m0_ack    = in_resp & gnt_q[0];
      bus.m0_err    = in_resp & gnt_q[0] & resp_err;
      bus.m0_rdata  = (in_resp & gnt_q[0]) ? resp_rdata : 32'h0;

      bus.m1_ack    = in_resp & gnt_q[1];
      bus.m1_err    = in_resp & gnt_q[1] & resp_err;
      bus.m1_rdata  = (in_resp & gnt_q[1]) ? resp_rdata : 32'h0;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, each cycle of
// every transaction compared against a transaction-level reference model.
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bus_arbiter_if bif ();

   bus_arbiter #(
      .GPIO_BASE(32'hF000_0000),
      .GPIO_END (32'hF000_0006)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bif)
   );

   int n_asserts = 0;
   int n_fail = 0;
   int last_served = 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // 0 = memory, 1 = GPIO (six bytes from the base), 2 = unmapped
   function automatic int target_of(input logic [31:0] a);
      if (a < 32'hF000_0000) return 0;
      if ((a - 32'hF000_0000) < 32'd6) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 4))
         0: return $urandom & 32'h7FFF_FFFC;
         1: return 32'hF000_0000 + 32'($urandom_range(0, 5));
         2: return 32'hF000_0006 + 32'($urandom_range(0, 1000));
         3: return 32'hEFFF_FFFC;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Entered just after a clock edge with the arbiter idle; runs one full transaction.
   task automatic apply_stimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic [31:0] mrd, input logic [31:0] grd,
                                 input bit hold);
      int          w;
      int          t;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;

      bif.m0_req = r0; bif.m0_we = w0; bif.m0_addr = a0; bif.m0_wdata = d0;
      bif.m1_req = r1; bif.m1_we = w1; bif.m1_addr = a1; bif.m1_wdata = d1;
      bif.mem_rdata = mrd;
      bif.gpio_rdata = grd;

      w  = (r0 && r1) ? ((last_served == 1) ? 0 : 1) : (r1 ? 1 : 0);
      we = (w == 1) ? w1 : w0;
      a  = (w == 1) ? a1 : a0;
      d  = (w == 1) ? d1 : d0;
      t  = target_of(a);
      exp_rd = (!we && t == 0) ? mrd : ((!we && t == 1) ? grd : 32'h0);

      @(negedge clk);
      check_output("idle_gnt", 32'(bif.gnt), 32'h0);
      check_output("idle_acks", 32'({bif.m0_ack, bif.m1_ack}), 32'h0);
      check_output("idle_strobes", 32'({bif.mem_we, bif.gpio_we}), 32'h0);

      @(posedge clk); #1;
      @(negedge clk);
      check_output("access_gnt", 32'(bif.gnt), (w == 1) ? 32'h2 : 32'h1);
      check_output("access_bus_addr", bif.bus_addr, a);
      check_output("access_bus_wdata", bif.bus_wdata, d);
      check_output("access_mem_we", 32'(bif.mem_we), 32'(we && t == 0));
      check_output("access_gpio_we", 32'(bif.gpio_we), 32'(we && t == 1));
      check_output("access_acks", 32'({bif.m0_ack, bif.m1_ack}), 32'h0);

      @(posedge clk); #1;
      @(negedge clk);
      check_output("resp_m0_ack", 32'(bif.m0_ack), 32'(w == 0));
      check_output("resp_m0_err", 32'(bif.m0_err), 32'(w == 0 && t == 2));
      check_output("resp_m0_rdata", bif.m0_rdata, (w == 0) ? exp_rd : 32'h0);
      check_output("resp_m1_ack", 32'(bif.m1_ack), 32'(w == 1));
      check_output("resp_m1_err", 32'(bif.m1_err), 32'(w == 1 && t == 2));
      check_output("resp_m1_rdata", bif.m1_rdata, (w == 1) ? exp_rd : 32'h0);
      check_output("resp_strobes", 32'({bif.mem_we, bif.gpio_we}), 32'h0);

      @(posedge clk); #1;
      last_served = w;
      if (!hold) begin
         bif.m0_req = 1'b0;
         bif.m1_req = 1'b0;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_gnt"}, 32'(bif.gnt), 32'h0);
      check_output({tag, "_acks"}, 32'({bif.m0_ack, bif.m1_ack}), 32'h0);
      check_output({tag, "_errs"}, 32'({bif.m0_err, bif.m1_err}), 32'h0);
      check_output({tag, "_m0_rdata"}, bif.m0_rdata, 32'h0);
      check_output({tag, "_m1_rdata"}, bif.m1_rdata, 32'h0);
      check_output({tag, "_strobes"}, 32'({bif.mem_we, bif.gpio_we}), 32'h0);
      check_output({tag, "_bus_addr"}, bif.bus_addr, 32'h0);
      check_output({tag, "_bus_wdata"}, bif.bus_wdata, 32'h0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        r0, r1, w0, w1;
      logic [31:0] a0, a1, d0, d1;
      bit          hold;

      reset = 1'b1;
      bif.m0_req = 1'b1; bif.m0_we = 1'b1; bif.m0_addr = 32'h0000_1234; bif.m0_wdata = 32'hCAFE_0001;
      bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = 32'hF000_0002; bif.m1_wdata = 32'hCAFE_0002;
      bif.mem_rdata = 32'h1357_9BDF;
      bif.gpio_rdata = 32'h2468_ACE0;

      $display("[TB] reset with both masters requesting");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      last_served = 1;

      $display("[TB] contention from reset");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0,
                        1'b1, 1'b1, 32'hF000_0002, 32'h0000_005A,
                        32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), (i != 3));
      end

      $display("[TB] directed single transactions");
      apply_stimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'hDEAD_BEEF, 32'h0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hF000_0004, 32'h0000_00A5,
                     32'h0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 32'hF000_0006, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h3333_3333, 32'h4444_4444, 1'b0);
      apply_stimulus(1'b1, 1'b1, 32'hEFFF_FFFC, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h0, 32'h0, 1'b0);

      $display("[TB] address boundary reads");
      apply_stimulus(1'b1, 1'b0, 32'hEFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h1111_1111, 32'h2222_2222, 1'b0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF000_0000, 32'h0,
                     32'h1111_1111, 32'h2222_2222, 1'b0);
      apply_stimulus(1'b1, 1'b0, 32'hF000_0005, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h1111_1111, 32'h2222_2222, 1'b0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF000_0006, 32'h0,
                     32'h1111_1111, 32'h2222_2222, 1'b0);

      $display("[TB] reset during an m1 read");
      bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = 32'h0000_0200;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check_output("midreset_access_gnt", 32'(bif.gnt), 32'h2);
      reset = 1'b1;
      bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 32'h0000_0300;
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_values("midreset");
      @(posedge clk); #1;
      reset = 1'b0;
      last_served = 1;
      apply_stimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,
                     32'h5555_AAAA, 32'h0, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 40; i++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         a0 = pick_addr();
         a1 = pick_addr();
         d0 = $urandom;
         d1 = $urandom;
         hold = ($urandom_range(0, 1) == 1);
         apply_stimulus(r0, w0, a0, d0, r1, w1, a1, d1, $urandom, $urandom, hold);
         if (!hold) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               @(negedge clk);
               check_output("gap_gnt", 32'(bif.gnt), 32'h0);
               @(posedge clk); #1;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
